// File: rtl/aes_key_pkg.sv
// AES key-schedule constants: key size encodings, Nk/Nr/T lookups, Rcon, S-box.
// Latency: none (functions and constants only).
// Backpressure: not applicable.
package aes_key_pkg;

    localparam logic [1:0] KEY_LEN_128  = 2'd0;
    localparam logic [1:0] KEY_LEN_192  = 2'd1;
    localparam logic [1:0] KEY_LEN_256  = 2'd2;
    localparam logic [1:0] KEY_LEN_RSVD = 2'd3;

    // Per-key-size schedule geometry, latched together at start.
    typedef struct packed {
        logic [3:0] nk;     // key words
        logic [3:0] nr;     // rounds
        logic [5:0] total;  // schedule words, 4*(nr+1)
    } key_cfg_t;

    function automatic logic [3:0] nk_of(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_128: return 4'd4;
            KEY_LEN_192: return 4'd6;
            KEY_LEN_256: return 4'd8;
            default:     return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_128: return 4'd10;
            KEY_LEN_192: return 4'd12;
            KEY_LEN_256: return 4'd14;
            default:     return 4'd0;
        endcase
    endfunction

    function automatic logic [5:0] total_of(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_128: return 6'd44;
            KEY_LEN_192: return 6'd52;
            KEY_LEN_256: return 6'd60;
            default:     return 6'd0;
        endcase
    endfunction

    function automatic key_cfg_t key_cfg(input logic [1:0] key_len);
        key_cfg_t c;
        c.nk    = nk_of(key_len);
        c.nr    = nr_of(key_len);
        c.total = total_of(key_len);
        return c;
    endfunction

    // Round constants; index 0 and indices past 10 are never used.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Forward S-box, entry 0x00 in the top byte, one row of 16 per line.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[11'd2047 - {b, 3'b000} -: 8];
    endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
// Latency: purely combinational.
// Backpressure: none; output follows input every cycle.
module aes_subword
    import aes_key_pkg::*;
(
    input  logic [31:0] data,
    output logic [31:0] subst
);

    assign subst = {sbox(data[31:24]), sbox(data[23:16]),
                    sbox(data[15:8]),  sbox(data[7:0])};

endmodule

// File: rtl/key_expansion_seq.sv
// Sequential AES-128/192/256 key schedule, one 32-bit word per clock, with a registered round-key read port.
// Latency: last word written T-Nk edges after start is accepted; round-key read is 1 cycle.
// Backpressure: start is only sampled in IDLE; starts while busy are dropped, reserved key_len pulses err.
module key_expansion_seq
    import aes_key_pkg::*;
#(
    parameter int MAX_WORDS = 60,
    parameter int RK_IDX_W  = 4
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          key_len,
    input  logic [255:0]        key_in,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                keys_valid,
    input  logic [RK_IDX_W-1:0] rk_idx,
    output logic [127:0]        rk_out
);

    localparam int IDX_W = $clog2(MAX_WORDS);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_EXPAND = 1'b1;

    logic [0:0]       state;
    logic [IDX_W-1:0] i_q;         // index of the word written this cycle
    logic [IDX_W-1:0] last_q;      // T-1 for the current run
    logic [2:0]       phase_q;     // i mod Nk
    logic [3:0]       rcon_idx_q;
    logic [3:0]       nk_q;
    logic [3:0]       nr_q;

    logic [31:0]      w_q [MAX_WORDS];

    key_cfg_t         cfg_in;
    logic             accept;
    logic             reject;

    logic [IDX_W-1:0] prev_addr;
    logic [IDX_W-1:0] back_addr;
    logic [31:0]      prev_w;
    logic [31:0]      back_w;
    logic [31:0]      sub_in;
    logic [31:0]      sub_out;
    logic [31:0]      t_w;
    logic [31:0]      new_w;
    logic [3:0]       phase_inc;

    logic [IDX_W-1:0] rd_base;
    logic             rd_in_range;

    assign cfg_in = key_cfg(key_len);
    assign accept = (state == ST_IDLE) && start && (key_len != KEY_LEN_RSVD);
    assign reject = (state == ST_IDLE) && start && (key_len == KEY_LEN_RSVD);

    // Expansion datapath: w[i] = w[i-Nk] ^ t(w[i-1]).
    assign prev_addr = i_q - IDX_W'(1);
    assign back_addr = i_q - IDX_W'(nk_q);
    assign prev_w    = w_q[prev_addr];
    assign back_w    = w_q[back_addr];

    // RotWord only on the phase-0 path; the 256-bit phase-4 path feeds w[i-1] straight in.
    assign sub_in = (phase_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    aes_subword u_subword (
        .data  (sub_in),
        .subst (sub_out)
    );

    // Select the schedule transform for this word position.
    always_comb begin
        t_w = prev_w;
        if (phase_q == 3'd0) begin
            t_w = sub_out ^ {rcon(rcon_idx_q), 24'h0};
        end else if ((nk_q == 4'd8) && (phase_q == 3'd4)) begin
            t_w = sub_out;
        end
    end

    assign new_w     = back_w ^ t_w;
    assign phase_inc = {1'b0, phase_q} + 4'd1;

    // Control FSM, counters and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            i_q        <= '0;
            last_q     <= '0;
            phase_q    <= '0;
            rcon_idx_q <= '0;
            nk_q       <= '0;
            nr_q       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            keys_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        nk_q       <= cfg_in.nk;
                        nr_q       <= cfg_in.nr;
                        last_q     <= IDX_W'(cfg_in.total) - IDX_W'(1);
                        i_q        <= IDX_W'(cfg_in.nk);
                        phase_q    <= '0;
                        rcon_idx_q <= 4'd1;
                        keys_valid <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_EXPAND;
                    end else if (reject) begin
                        err <= 1'b1;
                    end
                end
                ST_EXPAND: begin
                    i_q     <= i_q + IDX_W'(1);
                    phase_q <= (phase_inc == nk_q) ? 3'd0 : phase_inc[2:0];
                    if (phase_q == 3'd0) begin
                        rcon_idx_q <= rcon_idx_q + 4'd1;
                    end
                    if (i_q == last_q) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        keys_valid <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Schedule storage: key words on accept, one expanded word per EXPAND cycle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (accept) begin
                for (int k = 0; k < 8; k++) begin
                    if (k < int'(cfg_in.nk)) begin
                        w_q[k] <= key_in[255 - 32*k -: 32];
                    end
                end
            end else if (state == ST_EXPAND) begin
                w_q[i_q] <= new_w;
            end
        end
    end

    assign rd_base     = IDX_W'({rk_idx, 2'b00});
    assign rd_in_range = int'(rk_idx) <= int'(nr_q);

    // Registered round-key read; zero unless the schedule is complete and the index exists.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rk_out <= '0;
        end else if (keys_valid && rd_in_range) begin
            rk_out <= {w_q[rd_base],
                       w_q[rd_base + IDX_W'(1)],
                       w_q[rd_base + IDX_W'(2)],
                       w_q[rd_base + IDX_W'(3)]};
        end else begin
            rk_out <= '0;
        end
    end

endmodule

// File: tb/tb_key_expansion_seq.sv
// Scoreboard bench for key_expansion_seq: stimulus queues expected done/err/read events, a monitor checks them.
// Latency: done timing checked against E0 + (T-Nk); reads checked one cycle after rk_idx.
// Backpressure: exercises start while busy, start in the done cycle and reserved key_len.
module tb_key_expansion_seq;

    localparam int EV_DONE = 0;
    localparam int EV_ERR  = 1;
    localparam int EV_RK   = 2;

    localparam logic [255:0] K128 = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
    localparam logic [255:0] KJUNK = 256'hdeadbeef_01234567_89abcdef_fedcba98_76543210_0f1e2d3c_4b5a6978_a5a5a5a5;

    localparam logic [127:0] RK128_10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    localparam logic [127:0] RK192_12 = 128'he98ba06f_448c773c_8ecc7204_01002202;
    localparam logic [127:0] RK256_14 = 128'hfe4890d1_e6188d0b_046df344_706c631e;

    typedef struct {
        int           kind;
        int           cyc;
        logic [127:0] val;
    } exp_t;

    exp_t exp_q[$];

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'd0;
    logic [255:0] key_in = '0;
    logic [3:0]   rk_idx = 4'd0;
    logic         busy;
    logic         done;
    logic         err;
    logic         keys_valid;
    logic [127:0] rk_out;

    logic         rd_req = 1'b0;
    logic         rd_q = 1'b0;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    key_expansion_seq #(.MAX_WORDS(60), .RK_IDX_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_len    (key_len),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .keys_valid (keys_valid),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        rd_q <= rd_req;
    end

    function automatic string kname(input int kind);
        case (kind)
            EV_DONE: return "done";
            EV_ERR:  return "err";
            default: return "rk";
        endcase
    endfunction

    task automatic push_exp(input int kind, input int c, input logic [127:0] val);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Monitor side: pop the oldest expectation for each event the DUT presents.
    task automatic take(input int kind, input logic [127:0] act);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected at cycle %0d (nothing expected)", kname(kind), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
                errors++;
                $display("FAIL event_order got %s expected %s at cycle %0d", kname(kind), kname(e.kind), cyc);
            end else if (kind == EV_RK) begin
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL rk_out got %h expected %h", act, e.val);
                end
            end else if (cyc != e.cyc) begin
                errors++;
                $display("FAIL %s_timing got cycle %0d expected cycle %0d", kname(kind), cyc, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (err)  take(EV_ERR, '0);
        if (done) take(EV_DONE, '0);
        if (rd_q) take(EV_RK, rk_out);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after E0.
    task automatic start_run(input logic [1:0] kl, input logic [255:0] k, input int lat, input bit expect_done);
        key_len = kl;
        key_in  = k;
        start   = 1'b1;
        if (expect_done) push_exp(EV_DONE, cyc + 1 + lat, '0);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is high, or flags a timeout.
    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done_timeout got no done expected done within 100 cycles", name);
        end
    endtask

    task automatic rd(input logic [3:0] idx, input logic [127:0] exp);
        push_exp(EV_RK, 0, exp);
        rk_idx = idx;
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_done", 128'(done), 128'd0);
        chk("reset_err", 128'(err), 128'd0);
        chk("reset_keys_valid", 128'(keys_valid), 128'd0);
        chk("reset_rk_out", rk_out, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // AES-128 with an ignored start mid-run
        start_run(2'd0, K128, 40, 1'b1);
        repeat (10) @(negedge clk);
        chk("mid128_busy", 128'(busy), 128'd1);
        chk("mid128_keys_valid", 128'(keys_valid), 128'd0);
        key_len = 2'd2;
        key_in  = KJUNK;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("aes128");
        @(negedge clk);
        chk("aes128_keys_valid", 128'(keys_valid), 128'd1);
        rd(4'd0, K128[255:128]);
        rd(4'd10, RK128_10);
        for (int r = 11; r <= 14; r++) rd(4'(r), 128'd0);
        @(negedge clk);

        // Reserved key length
        key_len = 2'd3;
        key_in  = KJUNK;
        start   = 1'b1;
        push_exp(EV_ERR, cyc + 1, '0);
        @(negedge clk);
        start = 1'b0;
        chk("err_busy", 128'(busy), 128'd0);
        chk("err_keys_valid", 128'(keys_valid), 128'd1);
        @(negedge clk);
        chk("err_pulse_width", 128'(err), 128'd0);
        rd(4'd10, RK128_10);
        @(negedge clk);

        // AES-256 aborted by reset sampled at E20
        start_run(2'd2, K256, 52, 1'b0);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_done", 128'(done), 128'd0);
        chk("abort_err", 128'(err), 128'd0);
        chk("abort_keys_valid", 128'(keys_valid), 128'd0);
        chk("abort_rk_out", rk_out, 128'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_keys_valid_later", 128'(keys_valid), 128'd0);
        rd(4'd0, 128'd0);
        @(negedge clk);

        // AES-192
        start_run(2'd1, K192, 46, 1'b1);
        wait_done("aes192");
        @(negedge clk);
        rd(4'd12, RK192_12);
        rd(4'd13, 128'd0);
        rd(4'd0, K192[255:128]);
        @(negedge clk);

        // AES-128 followed by AES-256 started in the done cycle
        start_run(2'd0, K128, 40, 1'b1);
        wait_done("b2b_aes128");
        start_run(2'd2, K256, 52, 1'b1);
        chk("b2b_busy", 128'(busy), 128'd1);
        chk("b2b_keys_valid", 128'(keys_valid), 128'd0);
        wait_done("b2b_aes256");
        @(negedge clk);
        rd(4'd14, RK256_14);
        rd(4'd1, K256[127:0]);
        rd(4'd0, K256[255:128]);

        // Let the monitor drain outstanding expectations
        for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0 pending", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
